reg_rename_file: RTL and testbench

- Architectural register file plus register alias state. Sits directly downstream of the ROB's commit outputs and beside dispatch.
- Accepts up to 4 in-order commit writes per cycle and up to 4 rename (destination-claim) requests per cycle.
- Answers 8 source-operand lookups (2 per dispatch lane) with either a ready value or the ROB tag of the pending producer.
- On a pipeline flush, drops all pending renames.

---
 rtl/reg_rename_file.sv | 172 +++++++++++++++++
 tb/tb_reg_rename_file.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// Architectural register file with rename alias state: 4 commit writes, 4 renames and 8 source lookups per cycle.
// Optional zero-cycle commit-to-dispatch forwarding is enabled by defining COMMIT_BYPASS_EN.
module reg_rename_file #(
    parameter int unsigned NREG = 16,
    parameter int unsigned DW   = 16,
    parameter int unsigned TW   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  commit_we_flat,
    input  logic [4*$clog2(NREG)-1:0]   commit_target_flat,
    input  logic [4*DW-1:0]             commit_data_flat,
    input  logic [4*TW-1:0]             commit_tag_flat,
    input  logic                        flush,
    input  logic [3:0]                  rename_valid_flat,
    input  logic [4*$clog2(NREG)-1:0]   rename_target_flat,
    input  logic [4*TW-1:0]             rename_tag_flat,
    input  logic [8*$clog2(NREG)-1:0]   src_reg_flat,
    output logic [7:0]                  src_busy_flat,
    output logic [8*TW-1:0]             src_tag_flat,
    output logic [8*DW-1:0]             src_value_flat
);
    localparam int unsigned LANES = 4;
    localparam int unsigned SRCS  = 8;
    localparam int unsigned RW    = $clog2(NREG);

    logic [DW-1:0]   value_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [TW-1:0]   tag_q   [NREG];

    logic [DW-1:0]   value_d [NREG];
    logic [NREG-1:0] busy_d;
    logic [TW-1:0]   tag_d   [NREG];

    logic          c_we   [LANES];
    logic [RW-1:0] c_tgt  [LANES];
    logic [DW-1:0] c_data [LANES];
    logic [TW-1:0] c_tag  [LANES];
    logic          r_vld  [LANES];
    logic [RW-1:0] r_tgt  [LANES];
    logic [TW-1:0] r_tag  [LANES];
    logic [RW-1:0] s_reg  [SRCS];

    // Lane 0 occupies the most significant slice of every flat bus.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            c_we[k]   = commit_we_flat[LANES-1-k];
            c_tgt[k]  = commit_target_flat[(LANES-1-k)*RW +: RW];
            c_data[k] = commit_data_flat[(LANES-1-k)*DW +: DW];
            c_tag[k]  = commit_tag_flat[(LANES-1-k)*TW +: TW];
            r_vld[k]  = rename_valid_flat[LANES-1-k];
            r_tgt[k]  = rename_target_flat[(LANES-1-k)*RW +: RW];
            r_tag[k]  = rename_tag_flat[(LANES-1-k)*TW +: TW];
        end
        for (int unsigned n = 0; n < SRCS; n++) begin
            s_reg[n] = src_reg_flat[(SRCS-1-n)*RW +: RW];
        end
    end

    logic [NREG-1:0] cm_hit;
    logic [DW-1:0]   cm_data [NREG];
    logic [TW-1:0]   cm_tag  [NREG];

    // Next state: youngest commit per register, then flush or renames (highest lane wins).
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        cm_hit  = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cm_data[r] = '0;
            cm_tag[r]  = '0;
        end
        for (int unsigned r = 1; r < NREG; r++) begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (c_we[k] && c_tgt[k] == RW'(r)) begin
                    cm_hit[r]  = 1'b1;
                    cm_data[r] = c_data[k];
                    cm_tag[r]  = c_tag[k];
                end
            end
            if (cm_hit[r]) begin
                value_d[r] = cm_data[r];
                if (busy_q[r] && tag_q[r] == cm_tag[r]) begin
                    busy_d[r] = 1'b0;
                    tag_d[r]  = '0;
                end
            end
        end
        if (flush) begin
            busy_d = '0;
            for (int unsigned r = 0; r < NREG; r++) begin
                tag_d[r] = '0;
            end
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (r_vld[k] && r_tgt[k] != '0) begin
                    busy_d[r_tgt[k]] = 1'b1;
                    tag_d[r_tgt[k]]  = r_tag[k];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            for (int unsigned r = 0; r < NREG; r++) begin
                value_q[r] <= '0;
                tag_q[r]   <= '0;
            end
        end else begin
            busy_q <= busy_d;
            for (int unsigned r = 0; r < NREG; r++) begin
                value_q[r] <= value_d[r];
                tag_q[r]   <= tag_d[r];
            end
        end
    end

    logic          l_busy  [SRCS];
    logic [TW-1:0] l_tag   [SRCS];
    logic [DW-1:0] l_value [SRCS];
    logic          l_intra [SRCS];
    logic          l_byp   [SRCS];
    logic [DW-1:0] l_bdata [SRCS];

    // Source lookup: r0, then older same-group renames, then (optionally bypassed) state.
    always_comb begin
        src_busy_flat  = '0;
        src_tag_flat   = '0;
        src_value_flat = '0;
        for (int unsigned n = 0; n < SRCS; n++) begin
            l_busy[n]  = 1'b0;
            l_tag[n]   = '0;
            l_value[n] = '0;
            l_intra[n] = 1'b0;
            l_byp[n]   = 1'b0;
            l_bdata[n] = '0;
            if (s_reg[n] != '0) begin
                for (int unsigned j = 0; j < LANES; j++) begin
                    if (j < n / 2 && !flush && r_vld[j] && r_tgt[j] == s_reg[n]) begin
                        l_intra[n] = 1'b1;
                        l_tag[n]   = r_tag[j];
                    end
                end
`ifdef COMMIT_BYPASS_EN
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (busy_q[s_reg[n]] && c_we[k] && c_tgt[k] == s_reg[n]
                        && c_tag[k] == tag_q[s_reg[n]]) begin
                        l_byp[n]   = 1'b1;
                        l_bdata[n] = c_data[k];
                    end
                end
`endif
                if (l_intra[n]) begin
                    l_busy[n] = 1'b1;
                end else if (l_byp[n]) begin
                    l_value[n] = l_bdata[n];
                end else if (busy_q[s_reg[n]]) begin
                    l_busy[n] = 1'b1;
                    l_tag[n]  = tag_q[s_reg[n]];
                end else begin
                    l_value[n] = value_q[s_reg[n]];
                end
            end
            src_busy_flat[SRCS-1-n]            = l_busy[n];
            src_tag_flat[(SRCS-1-n)*TW +: TW]   = l_tag[n];
            src_value_flat[(SRCS-1-n)*DW +: DW] = l_value[n];
        end
    end
endmodule

// File: tb/tb_reg_rename_file.sv
// Self-checking bench for reg_rename_file: directed step table plus randomized traffic against a reference model.
module tb_reg_rename_file;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  commit_we_flat;
    logic [15:0] commit_target_flat;
    logic [63:0] commit_data_flat;
    logic [15:0] commit_tag_flat;
    logic        flush;
    logic [3:0]  rename_valid_flat;
    logic [15:0] rename_target_flat;
    logic [15:0] rename_tag_flat;
    logic [31:0] src_reg_flat;
    logic [7:0]  src_busy_flat;
    logic [31:0] src_tag_flat;
    logic [127:0] src_value_flat;

`ifdef COMMIT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_rename_file dut (
        .clk(clk), .rst(rst),
        .commit_we_flat(commit_we_flat), .commit_target_flat(commit_target_flat),
        .commit_data_flat(commit_data_flat), .commit_tag_flat(commit_tag_flat),
        .flush(flush),
        .rename_valid_flat(rename_valid_flat), .rename_target_flat(rename_target_flat),
        .rename_tag_flat(rename_tag_flat),
        .src_reg_flat(src_reg_flat),
        .src_busy_flat(src_busy_flat), .src_tag_flat(src_tag_flat), .src_value_flat(src_value_flat)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_val  [16];
    logic        m_busy [16];
    logic [3:0]  m_tag  [16];

    typedef struct {
        logic [3:0]  cwe;
        logic [15:0] ctgt;
        logic [63:0] cdata;
        logic [15:0] ctag;
        logic        fl;
        logic [3:0]  rv;
        logic [15:0] rtgt;
        logic [15:0] rtag;
        logic [31:0] src;
        int          chk;
        logic        eb;
        logic [3:0]  et;
        logic [15:0] ev;
        bit          adv;
    } step_t;

    step_t steps [25];

    function automatic step_t mk(logic [3:0] cwe, logic [15:0] ctgt, logic [63:0] cdata,
                                 logic [15:0] ctag, logic fl, logic [3:0] rv, logic [15:0] rtgt,
                                 logic [15:0] rtag, logic [31:0] src, int chk, logic eb,
                                 logic [3:0] et, logic [15:0] ev, bit adv);
        step_t s;
        s.cwe = cwe; s.ctgt = ctgt; s.cdata = cdata; s.ctag = ctag; s.fl = fl;
        s.rv = rv; s.rtgt = rtgt; s.rtag = rtag; s.src = src; s.chk = chk;
        s.eb = eb; s.et = et; s.ev = ev; s.adv = adv;
        return s;
    endfunction

    function automatic logic [3:0]  f_ctgt(int k);  return commit_target_flat[(3-k)*4 +: 4]; endfunction
    function automatic logic [15:0] f_cdata(int k); return commit_data_flat[(3-k)*16 +: 16]; endfunction
    function automatic logic [3:0]  f_ctag(int k);  return commit_tag_flat[(3-k)*4 +: 4]; endfunction
    function automatic logic [3:0]  f_rtgt(int k);  return rename_target_flat[(3-k)*4 +: 4]; endfunction
    function automatic logic [3:0]  f_rtag(int k);  return rename_tag_flat[(3-k)*4 +: 4]; endfunction

    // Expected {busy, tag, value} for source n from the architectural rules.
    function automatic logic [20:0] ref_lookup(int n);
        logic [3:0] s;
        s = src_reg_flat[(7-n)*4 +: 4];
        if (s == 4'd0) return 21'd0;
        if (!flush) begin
            for (int j = n / 2 - 1; j >= 0; j--) begin
                if (rename_valid_flat[3-j] && f_rtgt(j) == s) return {1'b1, f_rtag(j), 16'h0};
            end
        end
        if (m_busy[s]) begin
`ifdef COMMIT_BYPASS_EN
            for (int k = 3; k >= 0; k--) begin
                if (commit_we_flat[3-k] && f_ctgt(k) == s && f_ctag(k) == m_tag[s])
                    return {1'b0, 4'h0, f_cdata(k)};
            end
`endif
            return {1'b1, m_tag[s], 16'h0};
        end
        return {1'b0, 4'h0, m_val[s]};
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++) begin
            m_val[r] = '0; m_busy[r] = 1'b0; m_tag[r] = '0;
        end
    endtask

    // Apply the current inputs to the model as one clock edge.
    task automatic model_edge();
        logic [15:0] nv [16];
        logic        nb [16];
        logic [3:0]  nt [16];
        int y;
        for (int r = 0; r < 16; r++) begin
            nv[r] = m_val[r]; nb[r] = m_busy[r]; nt[r] = m_tag[r];
        end
        for (int r = 1; r < 16; r++) begin
            y = -1;
            for (int k = 0; k < 4; k++)
                if (commit_we_flat[3-k] && f_ctgt(k) == 4'(r)) y = k;
            if (y >= 0) begin
                nv[r] = f_cdata(y);
                if (m_busy[r] && m_tag[r] == f_ctag(y)) nb[r] = 1'b0;
            end
        end
        for (int r = 0; r < 16; r++) begin
            if (flush) begin
                nb[r] = 1'b0; nt[r] = '0;
            end
        end
        if (!flush) begin
            for (int k = 0; k < 4; k++) begin
                if (rename_valid_flat[3-k] && f_rtgt(k) != 4'd0) begin
                    nb[f_rtgt(k)] = 1'b1; nt[f_rtgt(k)] = f_rtag(k);
                end
            end
        end
        for (int r = 0; r < 16; r++) begin
            m_val[r] = nv[r]; m_busy[r] = nb[r]; m_tag[r] = nt[r];
        end
    endtask

    task automatic check_src(input string nm, input int n, input logic eb,
                             input logic [3:0] et, input logic [15:0] ev);
        logic ab; logic [3:0] at; logic [15:0] av;
        ab = src_busy_flat[7-n];
        at = src_tag_flat[(7-n)*4 +: 4];
        av = src_value_flat[(7-n)*16 +: 16];
        n_cmp++;
        if (ab !== eb || at !== et || av !== ev) begin
            n_bad++;
            $display("FAIL %s src%0d: got busy=%b tag=%h value=%h, want busy=%b tag=%h value=%h",
                     nm, n, ab, at, av, eb, et, ev);
        end
    endtask

    task automatic drive_idle();
        commit_we_flat = '0; commit_target_flat = '0; commit_data_flat = '0; commit_tag_flat = '0;
        flush = 1'b0; rename_valid_flat = '0; rename_target_flat = '0; rename_tag_flat = '0;
    endtask

    task automatic drive_random();
        logic [3:0] t;
        for (int k = 0; k < 4; k++) begin
            t = 4'($urandom_range(0, 7));
            commit_we_flat[3-k]            = 1'($urandom_range(0, 1));
            commit_target_flat[(3-k)*4 +: 4] = t;
            commit_data_flat[(3-k)*16 +: 16] = 16'($urandom);
            commit_tag_flat[(3-k)*4 +: 4]    = ($urandom_range(0, 2) != 0) ? m_tag[t] : 4'($urandom);
            rename_valid_flat[3-k]         = ($urandom_range(0, 3) == 0);
            rename_target_flat[(3-k)*4 +: 4] = 4'($urandom_range(0, 7));
            rename_tag_flat[(3-k)*4 +: 4]    = 4'($urandom);
        end
        flush = ($urandom_range(0, 19) == 0);
        src_reg_flat = $urandom & 32'h7777_7777;
    endtask

    task automatic check_all_zero(input string nm);
        for (int n = 0; n < 8; n++) check_src(nm, n, 1'b0, 4'h0, 16'h0);
    endtask

    initial begin
        // Directed steps; src nibble/lane 0 is the most significant.
        steps[0]  = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h8, 16'h3000, 16'h5000, 32'h0030_0000, 2, 1, 4'h5, 16'h0, 1);
        steps[1]  = mk(4'h8, 16'h3000, 64'h1234_0000_0000_0000, 16'h5000, 0, 4'h0, 16'h0, 16'h0,
                       32'h3000_0000, 0, !BYP, BYP ? 4'h0 : 4'h5, BYP ? 16'h1234 : 16'h0, 1);
        steps[2]  = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 32'h3000_0000, 0, 0, 4'h0, 16'h1234, 1);
        steps[3]  = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h8, 16'h3000, 16'h5000, 32'h3000_0000, 0, 0, 4'h0, 16'h1234, 1);
        steps[4]  = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h8, 16'h3000, 16'h9000, 32'h3000_0000, 0, 1, 4'h5, 16'h0, 1);
        steps[5]  = mk(4'h8, 16'h3000, 64'hAAAA_0000_0000_0000, 16'h5000, 0, 4'h0, 16'h0, 16'h0,
                       32'h3000_0000, 0, 1, 4'h9, 16'h0, 1);
        steps[6]  = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 32'h3000_0000, 0, 1, 4'h9, 16'h0, 1);
        steps[7]  = mk(4'h8, 16'h3000, 64'hBBBB_0000_0000_0000, 16'h9000, 0, 4'h0, 16'h0, 16'h0,
                       32'h3000_0000, 0, !BYP, BYP ? 4'h0 : 4'h9, BYP ? 16'hBBBB : 16'h0, 1);
        steps[8]  = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 32'h3000_0000, 0, 0, 4'h0, 16'hBBBB, 1);
        steps[9]  = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'hA, 16'h2020, 16'h1030, 32'h2020_0020, 0, 0, 4'h0, 16'h0, 0);
        steps[10] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'hA, 16'h2020, 16'h1030, 32'h2020_0020, 2, 1, 4'h1, 16'h0, 0);
        steps[11] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'hA, 16'h2020, 16'h1030, 32'h2020_0020, 6, 1, 4'h3, 16'h0, 1);
        steps[12] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 32'h2000_0000, 0, 1, 4'h3, 16'h0, 1);
        steps[13] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h8, 16'h4000, 16'h7000, 32'h0040_0000, 2, 1, 4'h7, 16'h0, 1);
        steps[14] = mk(4'h8, 16'h0000, 64'h0041_0000_0000_0000, 16'h0, 1, 4'h8, 16'h5000, 16'h8000,
                       32'h0050_0000, 2, 0, 4'h0, 16'h0, 1);
        steps[15] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 32'h4500_0000, 0, 0, 4'h0, 16'h0, 0);
        steps[16] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 32'h4500_0000, 1, 0, 4'h0, 16'h0, 0);
        steps[17] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 32'h0200_0000, 0, 0, 4'h0, 16'h0, 0);
        steps[18] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 32'h0200_0000, 1, 0, 4'h0, 16'h0, 1);
        steps[19] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h8, 16'h6000, 16'h2000, 32'h0060_0000, 2, 1, 4'h2, 16'h0, 1);
        steps[20] = mk(4'h8, 16'h6000, 64'h0055_0000_0000_0000, 16'h2000, 0, 4'h0, 16'h0, 16'h0,
                       32'h0060_0000, 2, !BYP, BYP ? 4'h0 : 4'h2, BYP ? 16'h0055 : 16'h0, 1);
        steps[21] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 32'h0060_0000, 2, 0, 4'h0, 16'h0055, 1);
        steps[22] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h8, 16'h6000, 16'h4000, 32'h0060_0000, 2, 1, 4'h4, 16'h0, 1);
        steps[23] = mk(4'h8, 16'h6000, 64'h0077_0000_0000_0000, 16'h4000, 0, 4'h8, 16'h6000, 16'hA000,
                       32'h0060_0000, 2, 1, 4'hA, 16'h0, 1);
        steps[24] = mk(4'h0, 16'h0, 64'h0, 16'h0, 0, 4'h0, 16'h0, 16'h0, 32'h0060_0000, 2, 1, 4'hA, 16'h0, 1);

        drive_idle();
        src_reg_flat = 32'h1234_5678;
        rst = 1'b1;
        #3;
        check_all_zero("reset_state");
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();

        for (int i = 0; i < 25; i++) begin
            commit_we_flat = steps[i].cwe; commit_target_flat = steps[i].ctgt;
            commit_data_flat = steps[i].cdata; commit_tag_flat = steps[i].ctag;
            flush = steps[i].fl; rename_valid_flat = steps[i].rv;
            rename_target_flat = steps[i].rtgt; rename_tag_flat = steps[i].rtag;
            src_reg_flat = steps[i].src;
            #3;
            check_src($sformatf("step%0d", i), steps[i].chk, steps[i].eb, steps[i].et, steps[i].ev);
            if (steps[i].adv) begin
                @(posedge clk); #1;
            end
        end

        // Restart from a clean state for the randomized phase.
        drive_idle();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;

        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                drive_random();
                rst = 1'b1;
                #3;
                @(posedge clk); #1;
                rst = 1'b0;
                model_reset();
                drive_idle();
                src_reg_flat = $urandom | 32'h1111_1111;
                #3;
                check_all_zero("mid_reset");
                @(posedge clk); #1;
            end
            drive_random();
            #3;
            for (int n = 0; n < 8; n++) begin
                logic [20:0] e;
                e = ref_lookup(n);
                check_src($sformatf("rand%0d", c), n, e[20], e[19:16], e[15:0]);
            end
            @(posedge clk);
            model_edge();
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
